usb_upload_arbiter: RTL and testbench
=====================================

// Module: usb_upload_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that shares the single USB CDC upload path
//  (60 MHz PHY_CLK domain) between upload sources. Sources are command replies,
//  DSM results and digital-capture bursts. Once a source is granted, it is held
//  until that source's last byte is accepted. A stalled source is evicted by a
//  timeout, so one hung handler cannot block uploads from the others.
//  Sits between the cdc command/handler fabric and USB_CDC's upload input.
// PARAMETERS
//  NUM_SRC     3      number of requesters, 2..8; index 0 wins first after reset
//  TIMEOUT_CYC 4096   idle cycles mid-packet before the grant is revoked, >=2
// PORTS
//  clk            in   1          system clock (PHY_CLK, 60 MHz)
//  rst_n          in   1          synchronous active-low reset
//  src_data       in   8*NUM_SRC  byte per source; src i at [8i+7:8i]
//  src_valid      in   NUM_SRC    source i presents a byte
//  src_last       in   NUM_SRC    byte is the final byte of the packet
//  src_ready      out  NUM_SRC    byte of source i accepted this cycle
//  upload_data    out  8          byte to USB_CDC
//  upload_valid   out  1          upload_data valid
//  upload_ready   in   1          USB_CDC accepts upload byte
//  grant_id       out  3          index of currently granted source
//  busy           out  1          a packet is in progress (state XFER)
//  timeout_err    out  1          1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset values
//   - upload_valid=0, upload_data=0, src_ready=0, busy=0, grant_id=0, timeout_err=0.
//   - rr_ptr = NUM_SRC-1, so source 0 has first priority.
//  Handshakes
//   - Output side is valid/ready. A byte transfers on upload_valid&&upload_ready.
//   - upload_data is held stable while upload_valid=1 and upload_ready=0.
//   - Source side uses a combinational ready:
//       src_ready[i] = busy && grant_id==i && src_valid[i] && (!upload_valid || upload_ready)
//   - An accepted byte is loaded into the single output register and appears on
//     upload_valid on the next cycle (latency 1).
//   - With upload_ready held high, full throughput is 1 byte/cycle.
//  FSM
//   - IDLE:
//     - If any src_valid is set, pick the first set index searching upward
//       (with wrap) from rr_ptr+1.
//     - Register it into grant_id and go to XFER. No byte is accepted in this cycle.
//   - XFER:
//     - Accept bytes from the granted source only.
//     - When a byte with src_last=1 is accepted: rr_ptr<=grant_id, go to IDLE.
//       This applies to 1-byte packets as well.
//   - XFER timeout:
//     - to_cnt clears on every accepted byte.
//     - to_cnt increments only when the granted src_valid=0.
//     - Backpressure from upload_ready=0 never advances to_cnt.
//     - When to_cnt reaches TIMEOUT_CYC-1: pulse timeout_err, rr_ptr<=grant_id,
//       go to IDLE. The partial packet is not padded.
//  Boundary rules
//   - Simultaneous requests: round-robin order only; no fixed priority after
//     the first grant.
//   - Non-granted sources see src_ready=0 and must hold their data.
//   - Output register content still drains in IDLE (upload_valid remains until
//     accepted). A new grant can be issued while it drains.
//   - A request arriving on the same cycle a packet ends is considered in the
//     following IDLE cycle. Gap between packets is at least 1 cycle.
//   - A granted source dropping valid mid-packet is legal until timeout.
//   - Reset mid-packet: all state clears and any in-flight byte is discarded.
//   - grant_id is zero-extended; for NUM_SRC<8, unused indices never occur.
// TESTING
//  1 Single packet: src1 sends 0xA5,0x5A(last), ready=1
//    -> upload bytes 0xA5,0x5A on consecutive cycles; busy falls after last; grant_id=1.
//  2 Contention: src0,1,2 each hold a 2-byte packet from reset
//    -> output order is src0, src1, src2 packets; no interleaving of bytes.
//  3 Fairness: src0 always requesting, src2 requesting
//    -> grants alternate 0,2,0,2.
//  4 Backpressure: upload_ready low 100 cycles mid-packet (TIMEOUT_CYC=16)
//    -> upload_data held, no timeout_err, packet completes intact.
//  5 Timeout: TIMEOUT_CYC=16, src1 sends 1 byte then drops valid
//    -> timeout_err pulses exactly 16 cycles after last accept; next grant goes to src2.
//  6 Reset mid-packet: assert rst_n=0 for 1 cycle during XFER
//    -> upload_valid=0, busy=0, grant_id=0 next cycle; src0 wins next arbitration.

Source files
------------

// File: rtl/usb_upload_arbiter.sv
// Packet-level round-robin arbiter that shares the USB CDC upload byte path between sources.
// A grant is held until the source's last byte is accepted, or until it stalls for TIMEOUT_CYC cycles.
module usb_upload_arbiter #(
  parameter int NUM_SRC     = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           upload_data,
  output logic                 upload_valid,
  input  logic                 upload_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // Handshake: a byte moves whenever valid and ready are both high on a rising edge.
  // Source side ready is combinational; the output side is a single registered stage.

  logic [0:0]         state;
  logic [2:0]         rr_ptr;
  logic [TW-1:0]      to_cnt;
  logic [NUM_SRC-1:0] gnt_onehot;
  logic [7:0]         gnt_data;
  logic               gnt_valid;
  logic               gnt_last;
  logic               accept;
  logic [2:0]         pick_id;
  logic               pick_found;
  logic [3:0]         cand;

  assign busy = (state == XFER);

  always_comb begin
    gnt_onehot = '0;
    gnt_data   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 3'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_data      = src_data[8*i +: 8];
      end
    end
  end

  assign gnt_valid = |(src_valid & gnt_onehot);
  assign gnt_last  = |(src_last & gnt_onehot);
  assign src_ready = (busy && (!upload_valid || upload_ready)) ? (src_valid & gnt_onehot) : '0;
  assign accept    = |src_ready;

  // Search upward from the source after the last one served, wrapping at NUM_SRC.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = 4'(rr_ptr) + 4'(k);
      if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      if (!pick_found && ((src_valid >> cand) & NUM_SRC'(1)) != '0) begin
        pick_found = 1'b1;
        pick_id    = cand[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= 3'(NUM_SRC - 1);
      grant_id     <= '0;
      to_cnt       <= '0;
      timeout_err  <= 1'b0;
      upload_valid <= 1'b0;
      upload_data  <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (accept) begin
        upload_valid <= 1'b1;
        upload_data  <= gnt_data;
      end else if (upload_ready) begin
        upload_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            to_cnt   <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            to_cnt <= '0;
            if (gnt_last) begin
              rr_ptr <= grant_id;
              state  <= IDLE;
            end
          end else if (!gnt_valid) begin
            // Only a silent source ages the grant; output backpressure does not.
            if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
              timeout_err <= 1'b1;
              rr_ptr      <= grant_id;
              state       <= IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_upload_arbiter.sv
// Directed bench for usb_upload_arbiter: per-source byte queues feed the DUT,
// upload bytes are captured and compared against hand-built expected sequences.
module tb_usb_upload_arbiter;

  localparam int NUM_SRC     = 3;
  localparam int TIMEOUT_CYC = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [8*NUM_SRC-1:0] src_data = '0;
  logic [NUM_SRC-1:0]   src_valid = '0;
  logic [NUM_SRC-1:0]   src_last = '0;
  logic [NUM_SRC-1:0]   src_ready;
  logic [7:0]           upload_data;
  logic                 upload_valid;
  logic                 upload_ready = 1'b1;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  usb_upload_arbiter #(.NUM_SRC(NUM_SRC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .upload_data(upload_data), .upload_valid(upload_valid), .upload_ready(upload_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Queue entries are {last, data}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [NUM_SRC-1:0] fire;
  int vectors = 0;
  int miscompares = 0;
  int to_pulses = 0;

  task automatic drive();
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    if (q0.size() != 0) begin src_valid[0] = 1'b1; src_data[7:0]   = q0[0][7:0]; src_last[0] = q0[0][8]; end
    if (q1.size() != 0) begin src_valid[1] = 1'b1; src_data[15:8]  = q1[0][7:0]; src_last[1] = q1[0][8]; end
    if (q2.size() != 0) begin src_valid[2] = 1'b1; src_data[23:16] = q2[0][7:0]; src_last[2] = q2[0][8]; end
  endtask

  task automatic step();
    @(negedge clk);
    fire = rst_n ? (src_valid & src_ready) : '0;
    if (rst_n && upload_valid && upload_ready) out_q.push_back(upload_data);
    @(posedge clk);
    #1;
    if (fire[0]) void'(q0.pop_front());
    if (fire[1]) void'(q1.pop_front());
    if (fire[2]) void'(q2.pop_front());
    if (timeout_err) to_pulses++;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    upload_ready = 1'b1;
    drive();
    step();
    step();
    rst_n = 1'b1;
    out_q.delete();
    to_pulses = 0;
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      step();
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && !busy && !upload_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (upload_valid !== 1'b0) begin miscompares++; $display("FAIL reset_upload_valid: got %0b expected 0", upload_valid); end
    vectors++; if (upload_data !== 8'h00) begin miscompares++; $display("FAIL reset_upload_data: got %02h expected 00", upload_data); end
    vectors++; if (src_ready !== 3'b000) begin miscompares++; $display("FAIL reset_src_ready: got %03b expected 000", src_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
  endtask

  task automatic test_single();
    do_reset();
    q1 = '{9'h0A5, 9'h15A};
    drive();
    step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %0b expected 1", busy); end
    vectors++; if (grant_id !== 3'd1) begin miscompares++; $display("FAIL single_grant: got %0d expected 1", grant_id); end
    vectors++; if (src_ready !== 3'b010) begin miscompares++; $display("FAIL single_src_ready: got %03b expected 010", src_ready); end
    step();
    vectors++; if (upload_valid !== 1'b1 || upload_data !== 8'hA5) begin miscompares++; $display("FAIL single_byte0: got v=%0b d=%02h expected v=1 d=a5", upload_valid, upload_data); end
    step();
    vectors++; if (upload_valid !== 1'b1 || upload_data !== 8'h5A) begin miscompares++; $display("FAIL single_byte1: got v=%0b d=%02h expected v=1 d=5a", upload_valid, upload_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %0b expected 0", busy); end
    step();
    vectors++; if (upload_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained: got %0b expected 0", upload_valid); end
    vectors++; if (grant_id !== 3'd1) begin miscompares++; $display("FAIL single_grant_hold: got %0d expected 1", grant_id); end
    exp_q = '{8'hA5, 8'h5A};
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL single_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_data[%0d]: got %02h expected %02h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    q0 = '{9'h001, 9'h102};
    q1 = '{9'h011, 9'h112};
    q2 = '{9'h021, 9'h122};
    drive();
    drain(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL contention_done: got 0 expected 1 (cycle budget expired)"); end
    exp_q = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22};
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL contention_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL contention_data[%0d]: got %02h expected %02h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    q0 = '{9'h1A0, 9'h1A1};
    q2 = '{9'h1C0, 9'h1C1};
    drive();
    drain(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fairness_done: got 0 expected 1 (cycle budget expired)"); end
    exp_q = '{8'hA0, 8'hC0, 8'hA1, 8'hC1};
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL fairness_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL fairness_data[%0d]: got %02h expected %02h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (to_pulses !== 0) begin miscompares++; $display("FAIL fairness_timeouts: got %0d expected 0", to_pulses); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad_hold;
    int bad_to;
    do_reset();
    q1 = '{9'h031, 9'h032, 9'h133};
    drive();
    step();
    step();
    vectors++; if (upload_valid !== 1'b1 || upload_data !== 8'h31) begin miscompares++; $display("FAIL bp_first: got v=%0b d=%02h expected v=1 d=31", upload_valid, upload_data); end
    upload_ready = 1'b0;
    bad_hold = 0;
    bad_to = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (upload_valid !== 1'b1 || upload_data !== 8'h31 || src_ready !== 3'b000) bad_hold++;
      if (timeout_err !== 1'b0) bad_to++;
    end
    vectors++; if (bad_hold !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad_hold); end
    vectors++; if (bad_to !== 0) begin miscompares++; $display("FAIL bp_no_timeout: got %0d pulse cycles expected 0", bad_to); end
    upload_ready = 1'b1;
    drain(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_done: got 0 expected 1 (cycle budget expired)"); end
    exp_q = '{8'h31, 8'h32, 8'h33};
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_data[%0d]: got %02h expected %02h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int hit;
    logic [2:0] g17;
    logic b17;
    logic te17;
    do_reset();
    q1 = '{9'h041};
    q2 = '{9'h151};
    drive();
    step();
    vectors++; if (grant_id !== 3'd1) begin miscompares++; $display("FAIL to_first_grant: got %0d expected 1", grant_id); end
    step();
    hit = 0;
    g17 = '0;
    b17 = 1'b0;
    te17 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (timeout_err === 1'b1 && hit == 0) hit = k;
      if (k == 17) begin g17 = grant_id; b17 = busy; te17 = timeout_err; end
    end
    vectors++; if (hit !== TIMEOUT_CYC) begin miscompares++; $display("FAIL to_latency: got %0d cycles expected %0d", hit, TIMEOUT_CYC); end
    vectors++; if (te17 !== 1'b0) begin miscompares++; $display("FAIL to_pulse_width: got %0b expected 0", te17); end
    vectors++; if (b17 !== 1'b1 || g17 !== 3'd2) begin miscompares++; $display("FAIL to_next_grant: got busy=%0b grant=%0d expected busy=1 grant=2", b17, g17); end
    drain(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_done: got 0 expected 1 (cycle budget expired)"); end
    vectors++; if (to_pulses !== 1) begin miscompares++; $display("FAIL to_pulse_count: got %0d expected 1", to_pulses); end
    exp_q = '{8'h41, 8'h51};
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL to_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL to_data[%0d]: got %02h expected %02h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    do_reset();
    q1 = '{9'h061, 9'h062, 9'h163};
    drive();
    step();
    step();
    vectors++; if (busy !== 1'b1 || upload_valid !== 1'b1) begin miscompares++; $display("FAIL rmp_pre: got busy=%0b v=%0b expected busy=1 v=1", busy, upload_valid); end
    q0.push_back(9'h171);
    rst_n = 1'b0;
    drive();
    step();
    vectors++; if (upload_valid !== 1'b0) begin miscompares++; $display("FAIL rmp_upload_valid: got %0b expected 0", upload_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmp_busy: got %0b expected 0", busy); end
    vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL rmp_grant_id: got %0d expected 0", grant_id); end
    rst_n = 1'b1;
    step();
    vectors++; if (busy !== 1'b1 || grant_id !== 3'd0) begin miscompares++; $display("FAIL rmp_regrant: got busy=%0b grant=%0d expected busy=1 grant=0", busy, grant_id); end
    drain(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmp_done: got 0 expected 1 (cycle budget expired)"); end
    exp_q = '{8'h71, 8'h62, 8'h63};
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rmp_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rmp_data[%0d]: got %02h expected %02h", i, out_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
